// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding,
// cmd_fun opcodes, the divide-by-zero fill value and the latched operand layout.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_MUL = 2'b10;
  localparam logic [1:0] FUN_DIV = 2'b11;

  // A divide by zero answers with every result bit set to this value.
  localparam logic DIV0_FILL_BIT = 1'b1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] fun;
  } operand_t;

  // A divide by zero is answered locally and never reaches the arithmetic unit.
  function automatic logic is_div_by_zero(input logic [1:0] fun, input logic [7:0] b);
    return (fun == FUN_DIV) && (b == 8'd0);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command, arithmetic-unit and response signals of the sequencer.
// slave is the sequencer's view; master is the surrounding system (requester,
// arithmetic unit and response consumer).
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [1:0]       cmd_fun;

  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [1:0]       alu_fun;
  logic             alu_enable;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_flag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun,
    input  alu_result, alu_carry, alu_flag,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_fun, alu_enable,
    output rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun,
    output alu_result, alu_carry, alu_flag,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_fun, alu_enable,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err
  );

endinterface

// File: rtl/alu_op_sequencer_timer.sv
// WAIT-state cycle counter. clear zeroes it, run advances it (saturating),
// expired flags the last permitted WAIT cycle (count == TIMEOUT-1).
module alu_seq_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = 4;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Next count: clear wins over run; hold at all-ones rather than wrap.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (run && (count_reg != '1)) begin
      count_next = count_reg + ONE;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == LAST_CNT);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one command at a time, drives the external
// arithmetic unit for a single enable cycle, waits (bounded) for its result flag
// and holds the response until the consumer takes it.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  alu_op_sequencer_if.slave bus,
  output logic [15:0]       op_count
);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  operand_t         operand_reg;
  operand_t         operand_next;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [WIDTH-1:0] rsp_data_next;
  logic             rsp_carry_reg;
  logic             rsp_carry_next;
  logic             rsp_err_reg;
  logic             rsp_err_next;
  logic [15:0]      op_count_reg;
  logic [15:0]      op_count_next;

  logic             timer_clear;
  logic             timer_run;
  logic             timer_expired;

  alu_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Next-state, data-register updates and Moore handshake outputs.
  always_comb begin
    state_next     = state_reg;
    operand_next   = operand_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_carry_next = rsp_carry_reg;
    rsp_err_next   = rsp_err_reg;
    op_count_next  = op_count_reg;
    timer_clear    = 1'b0;
    timer_run      = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.alu_enable = 1'b0;
    bus.rsp_valid  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          operand_next = {bus.cmd_a, bus.cmd_b, bus.cmd_fun};
          if (is_div_by_zero(bus.cmd_fun, bus.cmd_b)) begin
            state_next     = ST_RESP;
            rsp_data_next  = {WIDTH{DIV0_FILL_BIT}};
            rsp_carry_next = 1'b0;
            rsp_err_next   = 1'b1;
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // Single enable pulse; the timer starts from zero on the first WAIT cycle.
        bus.alu_enable = 1'b1;
        timer_clear    = 1'b1;
        state_next     = ST_WAIT;
      end

      ST_WAIT: begin
        // A result flag on the last permitted cycle still counts as success.
        if (bus.alu_flag) begin
          rsp_data_next  = bus.alu_result;
          rsp_carry_next = bus.alu_carry;
          rsp_err_next   = 1'b0;
          state_next     = ST_RESP;
        end else if (timer_expired) begin
          rsp_data_next  = '0;
          rsp_carry_next = 1'b0;
          rsp_err_next   = 1'b1;
          state_next     = ST_RESP;
        end else begin
          timer_run = 1'b1;
        end
      end

      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
          if (op_count_reg != 16'hFFFF) begin
            op_count_next = op_count_reg + 16'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand, response and completion-count registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      operand_reg   <= '0;
      rsp_data_reg  <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      operand_reg   <= operand_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_carry_reg <= rsp_carry_next;
      rsp_err_reg   <= rsp_err_next;
      op_count_reg  <= op_count_next;
    end
  end

  assign bus.alu_a     = operand_reg.a;
  assign bus.alu_b     = operand_reg.b;
  assign bus.alu_fun   = operand_reg.fun;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_carry = rsp_carry_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign op_count      = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a registered arithmetic-unit model,
// a scoreboard filled on command acceptance and drained on response handshake,
// and directed scenarios for nominal, divide-by-zero, hold, timeout and reset.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [1:0]       fun;
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             err;
    int               lat;
    int               en;
    int               acc_cyc;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic [15:0]      op_count;
  logic             flag_stuck;

  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               en_count = 0;
  int               accept_cnt = 0;
  logic             prev_valid;
  logic [WIDTH-1:0] last_data;
  logic             last_err;
  logic [WIDTH-1:0] rsp_log[$];
  exp_t             exp_q[$];

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .op_count (op_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Independent reference: full (WIDTH+1)-bit arithmetic, top bit is carry/borrow.
  function automatic logic [WIDTH:0] ref_calc(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] f);
    logic [WIDTH:0] x;
    logic [WIDTH:0] y;
    logic [WIDTH:0] p;
    x = {{(WIDTH-7){1'b0}}, a};
    y = {{(WIDTH-7){1'b0}}, b};
    case (f)
      2'b00:   ref_calc = x + y;
      2'b01:   ref_calc = x - y;
      2'b10:   begin p = x * y; ref_calc = {1'b0, p[WIDTH-1:0]}; end
      default: begin p = (y == 0) ? '0 : x / y; ref_calc = {1'b0, p[WIDTH-1:0]}; end
    endcase
  endfunction

  // Arithmetic-unit stub, integer based.
  function automatic logic [WIDTH:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                               input logic [1:0] f);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (f)
      2'b00:   r = ia + ib;
      2'b01:   r = ia - ib;
      2'b10:   r = ia * ib;
      default: r = (ib == 0) ? 0 : ia / ib;
    endcase
    if (f[1]) alu_model = {1'b0, r[WIDTH-1:0]};
    else      alu_model = r[WIDTH:0];
  endfunction

  // Registered unit: result and flag appear the cycle after the enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.alu_flag   <= 1'b0;
      bus.alu_result <= '0;
      bus.alu_carry  <= 1'b0;
    end else begin
      bus.alu_flag <= bus.alu_enable && !flag_stuck;
      if (bus.alu_enable) begin
        {bus.alu_carry, bus.alu_result} <= alu_model(bus.alu_a, bus.alu_b, bus.alu_fun);
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    exp_t           e;
    logic [WIDTH:0] r;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_q.delete();
        en_count   = 0;
        prev_valid = 1'b0;
      end else begin
        if (exp_q.size() != 0) begin
          check("busy_cmd_ready", bus.cmd_ready, 0);
          check("held_alu_a", bus.alu_a, exp_q[0].a);
          check("held_alu_b", bus.alu_b, exp_q[0].b);
          check("held_alu_fun", bus.alu_fun, exp_q[0].fun);
        end else begin
          check("idle_rsp_valid", bus.rsp_valid, 0);
          check("idle_alu_enable", bus.alu_enable, 0);
        end
        if (bus.alu_enable) en_count++;
        if (bus.rsp_valid && exp_q.size() != 0) begin
          if (!prev_valid) check("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
          check("rsp_data", bus.rsp_data, exp_q[0].data);
          check("rsp_carry", bus.rsp_carry, exp_q[0].carry);
          check("rsp_err", bus.rsp_err, exp_q[0].err);
          if (bus.rsp_ready) begin
            check("alu_en_pulses", en_count, exp_q[0].en);
            $display("rsp: a=%0d b=%0d fun=%0d data=%h carry=%b err=%b", exp_q[0].a,
                     exp_q[0].b, exp_q[0].fun, bus.rsp_data, bus.rsp_carry, bus.rsp_err);
            last_data = bus.rsp_data;
            last_err  = bus.rsp_err;
            rsp_log.push_back(bus.rsp_data);
            exp_q.delete(0);
            en_count = 0;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          e.a = bus.cmd_a;
          e.b = bus.cmd_b;
          e.fun = bus.cmd_fun;
          e.acc_cyc = cyc;
          if (bus.cmd_fun == FUN_DIV && bus.cmd_b == 8'd0) begin
            e.data = '1; e.carry = 1'b0; e.err = 1'b1; e.lat = 1; e.en = 0;
          end else if (flag_stuck) begin
            e.data = '0; e.carry = 1'b0; e.err = 1'b1; e.lat = TIMEOUT + 2; e.en = 1;
          end else begin
            r = ref_calc(bus.cmd_a, bus.cmd_b, bus.cmd_fun);
            e.data = r[WIDTH-1:0]; e.carry = r[WIDTH]; e.err = 1'b0; e.lat = 3; e.en = 1;
          end
          exp_q.push_back(e);
          accept_cnt++;
        end
        prev_valid = bus.rsp_valid;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                      input bit keep);
    int n;
    n = 0;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_fun = f;
    bus.cmd_valid = 1'b1;
    while (1) begin
      @(negedge CLK);
      if (bus.cmd_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", bus.cmd_ready, 1);
        break;
      end
    end
    @(posedge CLK);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < budget);
    if (exp_q.size() != 0) check("rsp_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!bus.rsp_valid && n < budget);
    if (!bus.rsp_valid) check("rsp_valid_timeout", bus.rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    RST = 1'b0;
    flag_stuck = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_fun = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu_enable", bus.alu_enable, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_op_count", op_count, 0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;

    // Add 200+100
    send(8'd200, 8'd100, FUN_ADD, 0);
    wait_done(20);
    check("add_data", last_data, 16'h012C);
    check("add_err", last_err, 0);
    check("add_op_count", op_count, 1);

    // Divide by zero
    send(8'd10, 8'd0, FUN_DIV, 0);
    wait_done(20);
    check("div0_data", last_data, 16'hFFFF);
    check("div0_err", last_err, 1);
    check("div0_op_count", op_count, 2);

    // Mul 15*17 with consumer stalled; a second command waits meanwhile
    bus.rsp_ready = 1'b0;
    send(8'd15, 8'd17, FUN_MUL, 1);
    bus.cmd_a = 8'd1;
    bus.cmd_b = 8'd2;
    bus.cmd_fun = FUN_ADD;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_rsp_data", bus.rsp_data, 16'h00FF);
      check("hold_rsp_valid", bus.rsp_valid, 1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_after_hs", bus.cmd_ready, 1);
    check("mul_op_count", op_count, 3);
    send(8'd1, 8'd2, FUN_ADD, 0);
    wait_done(20);
    check("queued_add_data", last_data, 16'h0003);
    check("queued_op_count", op_count, 4);

    // Flag never arrives: timeout
    flag_stuck = 1'b1;
    send(8'd3, 8'd4, FUN_ADD, 0);
    wait_done(30);
    flag_stuck = 1'b0;
    check("timeout_data", last_data, 0);
    check("timeout_err", last_err, 1);
    check("timeout_op_count", op_count, 5);

    // Reset pulsed while in WAIT
    flag_stuck = 1'b1;
    send(8'd9, 8'd9, FUN_ADD, 0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_alu_enable", bus.alu_enable, 0);
    check("midrst_rsp_data", bus.rsp_data, 0);
    check("midrst_rsp_carry", bus.rsp_carry, 0);
    check("midrst_rsp_err", bus.rsp_err, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_alu_a", bus.alu_a, 0);
    check("midrst_alu_b", bus.alu_b, 0);
    check("midrst_alu_fun", bus.alu_fun, 0);
    @(posedge CLK);
    #3 RST = 1'b1;
    flag_stuck = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("postrst_rsp_valid", bus.rsp_valid, 0);

    // Four back-to-back commands, sub 5-7 first
    rsp_log.delete();
    start = accept_cnt;
    send(8'd5, 8'd7, FUN_SUB, 1);
    send(8'd100, 8'd3, FUN_MUL, 1);
    send(8'd50, 8'd0, FUN_DIV, 1);
    send(8'd200, 8'd7, FUN_DIV, 0);
    wait_done(40);
    check("b2b_accepts", accept_cnt - start, 4);
    check("b2b_op_count", op_count, 4);
    check("b2b_rsp_count", rsp_log.size(), 4);
    if (rsp_log.size() == 4) begin
      check("sub_data", rsp_log[0], 16'hFFFE);
      check("b2b_mul_data", rsp_log[1], 16'd300);
      check("b2b_div0_data", rsp_log[2], 16'hFFFF);
      check("b2b_div_data", rsp_log[3], 16'd28);
    end

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
